// File: rtl/round_robin_dispatcher.sv
// rtl/round_robin_dispatcher.sv - credit-gated round-robin dispatcher with a one-beat output stage
module round_robin_dispatcher #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int CREDITS = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic [N-1:0] out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic [N-1:0] out_ready_i,
    input  logic [N-1:0] credit_ret_i,
    output logic         credit_ovf_o
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    logic          stage_valid;
    logic [N-1:0]  stage_tgt;
    logic [W-1:0]  stage_data;
    logic [CW-1:0] credit [N];
    logic [IW-1:0] last_idx;
    logic          ovf_q;

    logic [N-1:0]  eligible;
    logic [N-1:0]  sel_onehot;
    logic [IW-1:0] sel_idx;
    logic          sel_above;
    logic          xfer;
    logic          stage_free;
    logic          accept;
    logic [N-1:0]  dec_vec;
    logic [N-1:0]  ovf_vec;

    assign out_valid_o  = stage_valid ? stage_tgt : '0;
    assign out_data_o   = stage_data;
    assign credit_ovf_o = ovf_q;

    assign xfer       = |(out_valid_o & out_ready_i);
    assign stage_free = !stage_valid || xfer;
    assign in_ready_o = !rst_i && stage_free && (|eligible);
    assign accept     = in_valid_i && in_ready_o;
    assign dec_vec    = accept ? sel_onehot : '0;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            eligible[k] = (credit[k] != '0);
            ovf_vec[k]  = credit_ret_i[k] && !dec_vec[k] && (credit[k] == CMAX);
        end
    end

    // Descending scans so the last hit wins, leaving the lowest qualifying index.
    always_comb begin
        sel_idx   = '0;
        sel_above = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i] && (IW'(i) > last_idx)) begin
                sel_idx   = IW'(i);
                sel_above = 1'b1;
            end
        end
        if (!sel_above) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    sel_idx = IW'(i);
                end
            end
        end
        sel_onehot = N'(1) << sel_idx;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_valid <= 1'b0;
            stage_tgt   <= '0;
            last_idx    <= IW'(N - 1);
            ovf_q       <= 1'b0;
            for (int k = 0; k < N; k++) begin
                credit[k] <= CMAX;
            end
        end else begin
            if (accept) begin
                stage_valid <= 1'b1;
                stage_tgt   <= sel_onehot;
                stage_data  <= in_data_i;
                last_idx    <= sel_idx;
            end else if (xfer) begin
                stage_valid <= 1'b0;
            end
            // A same-cycle dispatch and return on one port cancel out.
            for (int k = 0; k < N; k++) begin
                if (dec_vec[k] && !credit_ret_i[k]) begin
                    credit[k] <= credit[k] - CW'(1);
                end else if (!dec_vec[k] && credit_ret_i[k] && (credit[k] != CMAX)) begin
                    credit[k] <= credit[k] + CW'(1);
                end
            end
            if (|ovf_vec) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/round_robin_dispatcher.md
ROUND_ROBIN_DISPATCHER -- requirements
Module: round_robin_dispatcher

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of downstream consumer ports (N >= 2).
REQ-002 SHALL have parameter W, default 32, meaning payload width in bits.
REQ-003 SHALL have parameter CREDITS, default 4, meaning per-port credit count loaded at reset (1..15).
REQ-004 SHALL have clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have in_valid_i  input  1  upstream beat valid.
REQ-007 SHALL have in_data_i  input  W  upstream payload.
REQ-008 SHALL have in_ready_o  output  1  dispatcher accepts the upstream beat this cycle.
REQ-009 SHALL have out_valid_o  output  N  one-hot (or zero) valid toward consumer k.
REQ-010 SHALL have out_data_o  output  W  payload shared by all consumers.
REQ-011 SHALL have out_ready_i  input  N  consumer k accepts a beat.
REQ-012 SHALL have credit_ret_i  input  N  one-cycle pulse: consumer k returns one credit.
REQ-013 SHALL have credit_ovf_o  output  1  sticky error: credit returned to a port already at CREDITS.

Function
REQ-014 SHALL hold one output stage: valid bit, one-hot target register, W-bit data register.
REQ-015 SHALL drive out_valid_o = target register when stage valid, else all zero; out_data_o = data register.
REQ-016 SHALL complete an output transfer in any cycle where out_valid_o[k] & out_ready_i[k].
REQ-017 SHALL treat the stage as free when it is empty or completes a transfer this cycle.
REQ-018 SHALL keep a per-port credit counter, width sufficient for 0..CREDITS.
REQ-019 SHALL mark port k eligible when its credit counter is nonzero (current registered value, not including same-cycle returns).
REQ-020 SHALL drive in_ready_o = stage free AND at least one port eligible; in_ready_o SHALL NOT depend on in_valid_i.
REQ-021 SHALL select the target as the lowest-index eligible port strictly above the last-dispatched index; if none, the lowest-index eligible port.
REQ-022 SHALL, on in_valid_i & in_ready_o (accept), load data, one-hot target and valid=1 into the stage, and record the target as last-dispatched.
REQ-023 SHALL present an accepted beat on out_valid_o exactly one cycle after acceptance (latency 1); back-to-back accepts at full throughput when consumers keep out_ready_i high.
REQ-024 SHALL keep stage contents and last-dispatched pointer unchanged when no accept occurs; stage SHALL clear on transfer without a same-cycle accept.
REQ-025 SHALL decrement the target port credit by 1 on accept.
REQ-026 SHALL increment port k credit by 1 on credit_ret_i[k]; a simultaneous accept-decrement and return on the same port SHALL leave the count unchanged.
REQ-027 SHALL ignore a return to a port at CREDITS (no decrement in same cycle) and set credit_ovf_o, which stays 1 until reset.
REQ-028 SHALL never let a credit counter underflow or exceed CREDITS.
REQ-029 SHALL hold out_data_o and out_valid_o stable while out_valid_o is nonzero and the target's out_ready_i is low.

Reset
REQ-030 SHALL on rst_i: stage valid=0 (out_valid_o=0), every credit=CREDITS, last-dispatched = N-1 (port 0 first), credit_ovf_o=0; data register value is don't-care.
REQ-031 SHALL discard any beat held in the stage when rst_i is asserted mid-operation; in_ready_o SHALL be 0 during reset cycles.

Verification (N=4, W=8, CREDITS=2)
REQ-032 SHALL cover: after reset, 4 beats 0xA0..0xA3 with all out_ready_i=1 -> out_valid_o 0001,0010,0100,1000 on consecutive cycles starting 1 cycle after first accept.
REQ-033 SHALL cover: no credit returns, continuous in_valid_i -> 8 beats accepted (2 per port), then in_ready_o=0; one credit_ret_i[2] pulse -> next beat goes to port 2 only.
REQ-034 SHALL cover: stage holds beat for port 1 with out_ready_i[1]=0 for 5 cycles -> out_valid_o=0010 and out_data_o stable, in_ready_o=0; release -> transfer and same-cycle accept of next beat.
REQ-035 SHALL cover: port 1 credit=1, accept to port 1 plus credit_ret_i[1] in same cycle -> port 1 credit remains 1.
REQ-036 SHALL cover: credit_ret_i[0] while port 0 credit=2 -> credit stays 2, credit_ovf_o=1 next cycle and held until rst_i.
REQ-037 SHALL cover: rst_i asserted while stage holds valid beat -> out_valid_o=0 next cycle, all credits 2, next accepted beat targets port 0.
